key_expansion_writer: RTL

AES-128 key-schedule engine that expands a 128-bit cipher key into the 44-column round-key table (`word1`) and writes it one byte per cycle over a single write port. It is the producer for the round-key table that the AddRoundKey stage reads. The table layout is byte `word[row][col]` at address `row*120 + col`. The block uses the same ap_ctrl_hs start/done/idle/ready handshake as the other AES stages.

---
 rtl/key_expansion_writer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_expansion_writer.sv
// -----------------------------------------------------------------------------
// key_expansion_writer
//
// AES-128 key-schedule engine. Expands a 128-bit cipher key into the 44-column
// round-key table and streams it out one byte per cycle over a single write
// port. Byte word[row][col] lands at address row*ROW_STRIDE + col.
//
// Ports:
//   ap_clk, ap_rst          clock, asynchronous active-high reset
//   ap_start/done/idle/ready ap_ctrl_hs block handshake
//   cipher_key[127:0]       key; byte k = cipher_key[127-8k -: 8] -> col k/4, row k%4
//   sbox_address0/ce0/q0    S-box ROM read port (data one cycle after ce0)
//   word1_address0/ce0/we0/d0  round-key table write port
//   working_key[63:0]       logic-locking key (only with KEY_EXP_LOCK_EN)
//
// Build option:
//   KEY_EXP_LOCK_EN  adds working_key; bit 10 diverts S_IDLE to S_WR and
//                    bit 12 diverts S_SUB to S_DONE. The correct key is all 0.
// -----------------------------------------------------------------------------
module key_expansion_writer #(
    parameter int unsigned ROW_STRIDE = 120,
    parameter int unsigned NUM_COLS   = 44
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic         ap_start,
    output logic         ap_done,
    output logic         ap_idle,
    output logic         ap_ready,
    input  logic [127:0] cipher_key,
`ifdef KEY_EXP_LOCK_EN
    input  logic [63:0]  working_key,
`endif
    output logic [7:0]   sbox_address0,
    output logic         sbox_ce0,
    input  logic [7:0]   sbox_q0,
    output logic [8:0]   word1_address0,
    output logic         word1_ce0,
    output logic         word1_we0,
    output logic [7:0]   word1_d0
);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_INIT = 5'b00010,
        S_SUB  = 5'b00100,
        S_WR   = 5'b01000,
        S_DONE = 5'b10000
    } state_e;

    localparam logic [5:0] LAST_COL = 6'(NUM_COLS);
    localparam logic [8:0] STRIDE   = 9'(ROW_STRIDE);

    state_e      state_q, state_d;
    logic [31:0] w_q [4];          // w[i-4] .. w[i-1]
    logic [31:0] w_d [4];
    logic [5:0]  i_q, i_d;         // column being produced
    logic [2:0]  c_q, c_d;         // byte / row / S-box step counter
    logic [7:0]  rcon_q, rcon_d;
    logic [31:0] sw_q, sw_d;       // SubWord(RotWord(w[i-1]))

    logic [31:0] t_word;
    logic [31:0] new_col;
    logic [8:0]  row_base;

`ifdef KEY_EXP_LOCK_EN
    logic unused_lock_bits;
    assign unused_lock_bits = ^{working_key[63:13], working_key[11], working_key[9:0]};
`endif

    // Row 0 is the most significant byte of a column word.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] r);
        case (r)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Every fourth column mixes in the substituted word and Rcon.
    assign t_word   = (i_q[1:0] == 2'd0) ? (sw_q ^ {rcon_q, 24'h000000}) : w_q[3];
    assign new_col  = w_q[0] ^ t_word;
    assign row_base = STRIDE * {7'd0, c_q[1:0]};

    // NOTE: data registers are reset along with the FSM so a mid-run abort
    // leaves no stale window feeding the next start.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            w_q     <= '{default: '0};
            i_q     <= '0;
            c_q     <= '0;
            rcon_q  <= '0;
            sw_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            w_q     <= w_d;
            i_q     <= i_d;
            c_q     <= c_d;
            rcon_q  <= rcon_d;
            sw_q    <= sw_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value defaulted first, so no path
        // through the case statement can infer a latch.
        state_d        = state_q;
        w_d            = w_q;
        i_d            = i_q;
        c_d            = c_q;
        rcon_d         = rcon_q;
        sw_d           = sw_q;
        ap_done        = 1'b0;
        ap_ready       = 1'b0;
        ap_idle        = 1'b0;
        sbox_ce0       = 1'b0;
        sbox_address0  = '0;
        word1_ce0      = 1'b0;
        word1_we0      = 1'b0;
        word1_address0 = '0;
        word1_d0       = '0;

        unique case (state_q)
            S_IDLE: begin
                ap_idle = !ap_start;
                if (ap_start) begin
                    w_d[0] = cipher_key[127:96];
                    w_d[1] = cipher_key[95:64];
                    w_d[2] = cipher_key[63:32];
                    w_d[3] = cipher_key[31:0];
                    i_d    = '0;
                    c_d    = '0;
                    rcon_d = 8'h01;
                    sw_d   = '0;
`ifdef KEY_EXP_LOCK_EN
                    state_d = working_key[10] ? S_WR : S_INIT;
`else
                    state_d = S_INIT;
`endif
                end
            end

            // Copy the key itself: columns 0..3, c walks the rows.
            S_INIT: begin
                word1_ce0      = 1'b1;
                word1_we0      = 1'b1;
                word1_address0 = row_base + {3'd0, i_q};
                word1_d0       = get_byte(w_q[i_q[1:0]], c_q[1:0]);
                if (c_q == 3'd3) begin
                    c_d = '0;
                    if (i_q == 6'd3) begin
                        i_d     = 6'd4;
                        state_d = S_SUB;
                    end else begin
                        i_d = i_q + 6'd1;
                    end
                end else begin
                    c_d = c_q + 3'd1;
                end
            end

            // Request bytes in RotWord order (rows 1,2,3,0); each ROM result
            // arrives a cycle later and is shifted in, so row 0 ends up in the MSB.
            S_SUB: begin
                if (c_q <= 3'd3) begin
                    sbox_ce0      = 1'b1;
                    sbox_address0 = get_byte(w_q[3], c_q[1:0] + 2'd1);
                end
                if (c_q != 3'd0) begin
                    sw_d = {sw_q[23:0], sbox_q0};
                end
                if (c_q == 3'd4) begin
                    c_d = '0;
`ifdef KEY_EXP_LOCK_EN
                    state_d = working_key[12] ? S_DONE : S_WR;
`else
                    state_d = S_WR;
`endif
                end else begin
                    c_d = c_q + 3'd1;
                end
            end

            S_WR: begin
                word1_ce0      = 1'b1;
                word1_we0      = 1'b1;
                word1_address0 = row_base + {3'd0, i_q};
                word1_d0       = get_byte(new_col, c_q[1:0]);
                if (c_q == 3'd3) begin
                    c_d = '0;
                    w_d = '{w_q[1], w_q[2], w_q[3], new_col};
                    if (i_q[1:0] == 2'd0) begin
                        rcon_d = xtime(rcon_q);
                    end
                    i_d = i_q + 6'd1;
                    if (i_d == LAST_COL) begin
                        state_d = S_DONE;
                    end else if (i_d[1:0] == 2'd0) begin
                        state_d = S_SUB;
                    end else begin
                        state_d = S_WR;
                    end
                end else begin
                    c_d = c_q + 3'd1;
                end
            end

            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
